// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: pipeline-register sequencing, load-use bubbles, forwarding selects,
// branch flush and memory-wait freeze with a sticky timeout and a saturating stall counter.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [3:0]       ID_Rn,
  input  logic [3:0]       ID_Rm,
  input  logic [3:0]       ID_Rd,
  input  logic             ID_Rn_Use,
  input  logic             ID_Rm_Use,
  input  logic             ID_Rd_Use,
  input  logic             EX_Load,
  input  logic             EX_rf,
  input  logic [3:0]       EX_Rd,
  input  logic             MEM_Load,
  input  logic             MEM_rf,
  input  logic [3:0]       MEM_Rd,
  input  logic             WB_rf,
  input  logic [3:0]       WB_Rd,
  input  logic             Branch_Taken,
  input  logic             Mem_Req,
  input  logic             Mem_Ready,
  output logic [1:0]       Fwd_A,
  output logic [1:0]       Fwd_B,
  output logic [1:0]       Fwd_C,
  output logic             PC_LE,
  output logic             IFID_LE,
  output logic             IDEX_LE,
  output logic             EXMEM_LE,
  output logic             IFID_CLR,
  output logic             IDEX_CLR,
  output logic             MEMWB_CLR,
  output logic             Mem_Timeout_Err,
  output logic [CNT_W-1:0] Stall_Count
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, MEMWAIT, ERROR} state_t;
  state_t state;
  logic [WW-1:0] wait_cnt;
  logic [3:0] src [3];
  logic [1:0] fwd [3];
  logic [2:0] use_v, hit;
  logic memwait, load_use, frozen, stalling, unused_mem_load;
  // MEM_Load only steers the external data-vs-ALU mux for the 10 select.
  assign unused_mem_load = MEM_Load;
  assign src = '{ID_Rn, ID_Rm, ID_Rd};
  assign use_v = {ID_Rd_Use, ID_Rm_Use, ID_Rn_Use};
  for (genvar i = 0; i < 3; i++) begin : g_fwd
    assign fwd[i] = !CLR || !use_v[i] ? 2'b00 :
                    EX_rf && !EX_Load && EX_Rd == src[i] ? 2'b01 :
                    MEM_rf && MEM_Rd == src[i] ? 2'b10 :
                    WB_rf && WB_Rd == src[i] ? 2'b11 : 2'b00;
    assign hit[i] = use_v[i] && EX_Rd == src[i];
  end
  assign Fwd_A = fwd[0];
  assign Fwd_B = fwd[1];
  assign Fwd_C = fwd[2];
  assign memwait = Mem_Req & !Mem_Ready;
  assign load_use = EX_Load & EX_rf & |hit;
  assign frozen = memwait | state == ERROR;
  assign stalling = frozen | load_use;
  assign PC_LE = CLR & !frozen & !load_use;
  assign IFID_LE = CLR & !frozen & !load_use;
  assign IDEX_LE = CLR & !frozen;
  assign EXMEM_LE = CLR & !frozen;
  assign IFID_CLR = !CLR | (!frozen & !load_use & Branch_Taken);
  assign IDEX_CLR = !CLR | (!frozen & load_use);
  assign MEMWB_CLR = !CLR | frozen;
  always_ff @(posedge CLK or negedge CLR)
    if (!CLR) begin
      state <= RUN;
      wait_cnt <= '0;
      Mem_Timeout_Err <= 1'b0;
      Stall_Count <= '0;
    end else begin
      if (stalling && ~&Stall_Count) Stall_Count <= Stall_Count + CNT_W'(1);
      case (state)
        RUN: if (memwait) begin
          state <= MEMWAIT;
          wait_cnt <= WW'(1);
        end
        MEMWAIT: if (!memwait) begin
          state <= RUN;
          wait_cnt <= '0;
        end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
          state <= ERROR;
          Mem_Timeout_Err <= 1'b1;
        end else wait_cnt <= wait_cnt + WW'(1);
        default: Mem_Timeout_Err <= 1'b1;
      endcase
    end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed checks of forwarding, load-use, branch flush,
// memory wait, timeout and asynchronous reset.
module tb_pipeline_hazard_controller;
  logic CLK, CLR;
  logic [3:0] ID_Rn, ID_Rm, ID_Rd, EX_Rd, MEM_Rd, WB_Rd;
  logic ID_Rn_Use, ID_Rm_Use, ID_Rd_Use, EX_Load, EX_rf, MEM_Load, MEM_rf, WB_rf;
  logic Branch_Taken, Mem_Req, Mem_Ready;
  logic [1:0] Fwd_A, Fwd_B, Fwd_C;
  logic PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, IFID_CLR, IDEX_CLR, MEMWB_CLR, Mem_Timeout_Err;
  logic [15:0] Stall_Count;
  int checks = 0;
  int errors = 0;

  pipeline_hazard_controller #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .CLK(CLK), .CLR(CLR),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd(ID_Rd),
    .ID_Rn_Use(ID_Rn_Use), .ID_Rm_Use(ID_Rm_Use), .ID_Rd_Use(ID_Rd_Use),
    .EX_Load(EX_Load), .EX_rf(EX_rf), .EX_Rd(EX_Rd),
    .MEM_Load(MEM_Load), .MEM_rf(MEM_rf), .MEM_Rd(MEM_Rd),
    .WB_rf(WB_rf), .WB_Rd(WB_Rd),
    .Branch_Taken(Branch_Taken), .Mem_Req(Mem_Req), .Mem_Ready(Mem_Ready),
    .Fwd_A(Fwd_A), .Fwd_B(Fwd_B), .Fwd_C(Fwd_C),
    .PC_LE(PC_LE), .IFID_LE(IFID_LE), .IDEX_LE(IDEX_LE), .EXMEM_LE(EXMEM_LE),
    .IFID_CLR(IFID_CLR), .IDEX_CLR(IDEX_CLR), .MEMWB_CLR(MEMWB_CLR),
    .Mem_Timeout_Err(Mem_Timeout_Err), .Stall_Count(Stall_Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle();
    {ID_Rn, ID_Rm, ID_Rd, EX_Rd, MEM_Rd, WB_Rd} = '0;
    {ID_Rn_Use, ID_Rm_Use, ID_Rd_Use, EX_Load, EX_rf, MEM_Load, MEM_rf, WB_rf} = '0;
    {Branch_Taken, Mem_Req, Mem_Ready} = '0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    CLR = 1'b0;
    #3;
    CLR = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle();
    CLR = 1'b0;
    EX_rf = 1'b1; EX_Rd = 4'd3; ID_Rn = 4'd3; ID_Rn_Use = 1'b1;
    #1;
    checks++; if ({PC_LE, IFID_LE, IDEX_LE, EXMEM_LE} !== 4'b0000) begin errors++; $display("FAIL rst_le got %b want 0000", {PC_LE, IFID_LE, IDEX_LE, EXMEM_LE}); end
    checks++; if ({IFID_CLR, IDEX_CLR, MEMWB_CLR} !== 3'b111) begin errors++; $display("FAIL rst_clr got %b want 111", {IFID_CLR, IDEX_CLR, MEMWB_CLR}); end
    checks++; if (Fwd_A !== 2'b00) begin errors++; $display("FAIL rst_fwd got %b want 00", Fwd_A); end
    checks++; if (Stall_Count !== 16'd0 || Mem_Timeout_Err !== 1'b0) begin errors++; $display("FAIL rst_state got cnt=%0d err=%b want 0 0", Stall_Count, Mem_Timeout_Err); end
    idle();
    CLR = 1'b1;
    #1;
    checks++; if ({PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, IFID_CLR, IDEX_CLR, MEMWB_CLR} !== 7'b1111000) begin errors++; $display("FAIL idle_ctl got %b want 1111000", {PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, IFID_CLR, IDEX_CLR, MEMWB_CLR}); end
    step();
  endtask

  task automatic test_forwarding();
    do_reset();
    EX_rf = 1'b1; EX_Rd = 4'd3; MEM_rf = 1'b1; MEM_Rd = 4'd3; WB_rf = 1'b1; WB_Rd = 4'd3;
    ID_Rn = 4'd3; ID_Rn_Use = 1'b1;
    #1;
    checks++; if (Fwd_A !== 2'b01) begin errors++; $display("FAIL fwd_ex got %b want 01", Fwd_A); end
    EX_rf = 1'b0; #1;
    checks++; if (Fwd_A !== 2'b10) begin errors++; $display("FAIL fwd_mem got %b want 10", Fwd_A); end
    MEM_rf = 1'b0; #1;
    checks++; if (Fwd_A !== 2'b11) begin errors++; $display("FAIL fwd_wb got %b want 11", Fwd_A); end
    ID_Rn_Use = 1'b0; #1;
    checks++; if (Fwd_A !== 2'b00) begin errors++; $display("FAIL fwd_nouse got %b want 00", Fwd_A); end
    idle();
    MEM_rf = 1'b1; MEM_Rd = 4'd7; WB_rf = 1'b1; WB_Rd = 4'd9;
    ID_Rm = 4'd7; ID_Rm_Use = 1'b1; ID_Rd = 4'd9; ID_Rd_Use = 1'b1; ID_Rn = 4'd1; ID_Rn_Use = 1'b1;
    #1;
    checks++; if ({Fwd_A, Fwd_B, Fwd_C} !== 6'b00_10_11) begin errors++; $display("FAIL fwd_abc got %b want 001011", {Fwd_A, Fwd_B, Fwd_C}); end
    idle();
    EX_Load = 1'b1; EX_rf = 1'b1; EX_Rd = 4'd3; MEM_rf = 1'b1; MEM_Rd = 4'd3; ID_Rn = 4'd3; ID_Rn_Use = 1'b1;
    #1;
    checks++; if (Fwd_A !== 2'b10) begin errors++; $display("FAIL fwd_exload got %b want 10", Fwd_A); end
    idle();
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    EX_Load = 1'b1; EX_rf = 1'b1; EX_Rd = 4'd5; ID_Rm = 4'd5; ID_Rm_Use = 1'b1;
    #1;
    checks++; if ({PC_LE, IFID_LE, IDEX_CLR} !== 3'b001) begin errors++; $display("FAIL lu_stall got %b want 001", {PC_LE, IFID_LE, IDEX_CLR}); end
    checks++; if ({IDEX_LE, EXMEM_LE, MEMWB_CLR} !== 3'b110) begin errors++; $display("FAIL lu_adv got %b want 110", {IDEX_LE, EXMEM_LE, MEMWB_CLR}); end
    step();
    checks++; if (Stall_Count !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", Stall_Count); end
    EX_Load = 1'b0; EX_rf = 1'b0; EX_Rd = 4'd0;
    MEM_Load = 1'b1; MEM_rf = 1'b1; MEM_Rd = 4'd5;
    #1;
    checks++; if (Fwd_B !== 2'b10) begin errors++; $display("FAIL lu_fwd got %b want 10", Fwd_B); end
    checks++; if ({PC_LE, IFID_LE, IDEX_CLR} !== 3'b110) begin errors++; $display("FAIL lu_release got %b want 110", {PC_LE, IFID_LE, IDEX_CLR}); end
    step();
    checks++; if (Stall_Count !== 16'd1) begin errors++; $display("FAIL lu_cnt2 got %0d want 1", Stall_Count); end
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    Branch_Taken = 1'b1;
    #1;
    checks++; if ({IFID_CLR, PC_LE, IFID_LE, IDEX_CLR} !== 4'b1110) begin errors++; $display("FAIL br_flush got %b want 1110", {IFID_CLR, PC_LE, IFID_LE, IDEX_CLR}); end
    EX_Load = 1'b1; EX_rf = 1'b1; EX_Rd = 4'd4; ID_Rd = 4'd4; ID_Rd_Use = 1'b1;
    #1;
    checks++; if ({IFID_CLR, IDEX_CLR, PC_LE} !== 3'b010) begin errors++; $display("FAIL br_lu got %b want 010", {IFID_CLR, IDEX_CLR, PC_LE}); end
    idle();
    step();
  endtask

  task automatic test_memwait();
    do_reset();
    Mem_Req = 1'b1; Mem_Ready = 1'b0;
    EX_Load = 1'b1; EX_rf = 1'b1; EX_Rd = 4'd2; ID_Rn = 4'd2; ID_Rn_Use = 1'b1;
    #1;
    checks++; if ({IDEX_CLR, IFID_CLR, IDEX_LE} !== 3'b000) begin errors++; $display("FAIL mw_over_lu got %b want 000", {IDEX_CLR, IFID_CLR, IDEX_LE}); end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, MEMWB_CLR, IFID_CLR} !== 6'b000010) begin errors++; $display("FAIL mw_freeze%0d got %b want 000010", k, {PC_LE, IFID_LE, IDEX_LE, EXMEM_LE, MEMWB_CLR, IFID_CLR}); end
      step();
      if (k == 0) begin EX_Load = 1'b0; EX_rf = 1'b0; end
    end
    Mem_Ready = 1'b1;
    #1;
    checks++; if ({PC_LE, EXMEM_LE, MEMWB_CLR} !== 3'b110) begin errors++; $display("FAIL mw_resume got %b want 110", {PC_LE, EXMEM_LE, MEMWB_CLR}); end
    checks++; if (Stall_Count !== 16'd3) begin errors++; $display("FAIL mw_cnt got %0d want 3", Stall_Count); end
    step();
    idle();
    #1;
    checks++; if ({PC_LE, MEMWB_CLR} !== 2'b10 || Stall_Count !== 16'd3) begin errors++; $display("FAIL mw_run got le=%b clr=%b cnt=%0d want 1 0 3", PC_LE, MEMWB_CLR, Stall_Count); end
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    Mem_Req = 1'b1; Mem_Ready = 1'b0;
    repeat (14) step();
    checks++; if (Mem_Timeout_Err !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", Mem_Timeout_Err); end
    step();
    checks++; if (Mem_Timeout_Err !== 1'b1) begin errors++; $display("FAIL to_set got %b want 1", Mem_Timeout_Err); end
    repeat (5) step();
    checks++; if (Stall_Count !== 16'd20) begin errors++; $display("FAIL to_cnt got %0d want 20", Stall_Count); end
    Mem_Ready = 1'b1; Mem_Req = 1'b0;
    #1;
    checks++; if ({PC_LE, EXMEM_LE, MEMWB_CLR} !== 3'b001) begin errors++; $display("FAIL to_frozen got %b want 001", {PC_LE, EXMEM_LE, MEMWB_CLR}); end
    step();
    checks++; if (Mem_Timeout_Err !== 1'b1 || Stall_Count !== 16'd21) begin errors++; $display("FAIL to_sticky got err=%b cnt=%0d want 1 21", Mem_Timeout_Err, Stall_Count); end
    idle();
    CLR = 1'b0;
    #1;
    checks++; if (Mem_Timeout_Err !== 1'b0 || Stall_Count !== 16'd0) begin errors++; $display("FAIL to_clr got err=%b cnt=%0d want 0 0", Mem_Timeout_Err, Stall_Count); end
    CLR = 1'b1;
    #1;
    checks++; if ({PC_LE, MEMWB_CLR} !== 2'b10) begin errors++; $display("FAIL to_run got %b want 10", {PC_LE, MEMWB_CLR}); end
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    Mem_Req = 1'b1; Mem_Ready = 1'b0;
    EX_rf = 1'b1; EX_Rd = 4'd2; ID_Rn = 4'd2; ID_Rn_Use = 1'b1;
    repeat (7) step();
    checks++; if (Stall_Count !== 16'd7) begin errors++; $display("FAIL ar_pre got %0d want 7", Stall_Count); end
    #2;
    CLR = 1'b0;
    #1;
    checks++; if (Stall_Count !== 16'd0 || Mem_Timeout_Err !== 1'b0) begin errors++; $display("FAIL ar_state got cnt=%0d err=%b want 0 0", Stall_Count, Mem_Timeout_Err); end
    checks++; if ({PC_LE, EXMEM_LE, IFID_CLR, IDEX_CLR, MEMWB_CLR, Fwd_A} !== 7'b00111_00) begin errors++; $display("FAIL ar_out got %b want 0011100", {PC_LE, EXMEM_LE, IFID_CLR, IDEX_CLR, MEMWB_CLR, Fwd_A}); end
    idle();
    CLR = 1'b1;
    #1;
    checks++; if ({PC_LE, IDEX_CLR, MEMWB_CLR} !== 3'b100) begin errors++; $display("FAIL ar_run got %b want 100", {PC_LE, IDEX_CLR, MEMWB_CLR}); end
    step();
  endtask

  initial begin
    idle();
    CLR = 1'b0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_memwait();
    test_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers of the ARM pipeline.
- Detects load-use hazards and inserts one bubble.
- Generates operand forwarding selects, flushes IF/ID on taken branches, and freezes the pipeline while data memory is not ready.
- A small FSM tracks memory-wait duration, raises a sticky timeout error, and keeps a saturating stall counter.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive memory-wait cycles before the ERROR state is entered.
- CNT_W, 16: width of Stall_Count.

Ports:
- CLK  in  1  pipeline clock; all state updates on its rising edge.
- CLR  in  1  asynchronous, active-low reset.
- ID_Rn, ID_Rm, ID_Rd  in  4 each  source registers of the instruction in ID (Rd is a source for stores).
- ID_Rn_Use, ID_Rm_Use, ID_Rd_Use  in  1 each  corresponding source is actually read.
- EX_Load, EX_rf  in  1 each  ID/EX load flag and register-file write enable.
- EX_Rd  in  4  ID/EX destination register.
- MEM_Load, MEM_rf  in  1 each  EX/MEM load flag and register-file write enable.
- MEM_Rd  in  4  EX/MEM destination register.
- WB_rf  in  1  MEM/WB register-file write enable.
- WB_Rd  in  4  MEM/WB destination register.
- Branch_Taken  in  1  branch resolved taken in ID.
- Mem_Req  in  1  MEM stage is accessing data memory.
- Mem_Ready  in  1  data memory completes the access this cycle.
- Fwd_A, Fwd_B, Fwd_C  out  2 each  operand source for Rn/Rm/Rd: 00 register file, 01 EX result, 10 MEM result, 11 WB result.
- PC_LE, IFID_LE, IDEX_LE, EXMEM_LE  out  1 each  load enables for the PC and pipeline registers.
- IFID_CLR, IDEX_CLR, MEMWB_CLR  out  1 each  synchronous active-high clear requests to the pipeline registers.
- Mem_Timeout_Err  out  1  sticky timeout flag.
- Stall_Count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (CLR=0, asynchronous): state=RUN, wait counter=0, Stall_Count=0, Mem_Timeout_Err=0.
- Outputs while CLR=0: all *_LE=0, all *_CLR=1, Fwd_*=00.
- Forwarding (combinational, per operand X; Fwd_X=00 if the operand's Use flag=0):
  - 01 if EX_rf & !EX_Load & EX_Rd==src;
  - else 10 if MEM_rf & MEM_Rd==src;
  - else 11 if WB_rf & WB_Rd==src;
  - else 00.
  - Priority is EX > MEM > WB. The external mux chooses data-memory or ALU output for 10 based on MEM_Load.
- Memwait (combinational) = Mem_Req & !Mem_Ready. Highest priority. When asserted:
  - PC_LE=IFID_LE=IDEX_LE=EXMEM_LE=0 and MEMWB_CLR=1 (bubble into WB);
  - IFID_CLR=0, IDEX_CLR=0.
- LoadUse (combinational) = EX_Load & EX_rf & EX_Rd matches any used ID source. When asserted and memwait=0:
  - PC_LE=IFID_LE=0, IDEX_CLR=1 (one bubble);
  - EX/MEM and MEM/WB advance normally;
  - Branch_Taken is ignored that cycle.
  - The next cycle the load sits in MEM and forwarding resolves via 10.
- Branch flush: Branch_Taken with no stall → IFID_CLR=1, all LE=1.
- Default (no event): all LE=1, all CLR=0.
- FSM:
  - RUN: memwait → MEMWAIT with wait counter=1.
  - MEMWAIT:
    - Mem_Ready=1 or Mem_Req=0 → RUN, wait counter=0 (that cycle behaves per the rules above).
    - Else wait counter+1; when the wait counter reaches MEM_TIMEOUT with memwait still high → ERROR and Mem_Timeout_Err=1.
  - ERROR: same outputs as memwait regardless of inputs. Exited only by reset.
- Stall_Count increments on each rising edge where memwait, loadUse or ERROR holds; it saturates at all-ones.
- Simultaneous events:
  - memwait + loadUse: memwait wins; loadUse is re-evaluated after release.
  - loadUse + Branch_Taken: stall wins and the branch is re-resolved next cycle.
- Reset mid-MEMWAIT or in ERROR returns to RUN immediately, asynchronously.

Test Plan:
- Forwarding priority: EX_rf=1, EX_Rd=3; MEM_rf=1, MEM_Rd=3; WB_rf=1, WB_Rd=3; ID_Rn=3, Rn_Use=1 → Fwd_A=01. Drop EX_rf → 10. Drop MEM_rf → 11. Set Rn_Use=0 → 00.
- Load-use: EX_Load=1, EX_rf=1, EX_Rd=5, ID_Rm=5, Rm_Use=1 → PC_LE=0, IFID_LE=0, IDEX_CLR=1 for exactly one cycle and Stall_Count=1. Next cycle with MEM_Rd=5, MEM_Load=1 → Fwd_B=10, no stall.
- Branch: Branch_Taken=1 alone → IFID_CLR=1, PC_LE=1. With a simultaneous load-use → IFID_CLR=0, IDEX_CLR=1.
- Memory wait: Mem_Req=1, Mem_Ready=0 for 3 cycles, then Mem_Ready=1 → all LE=0 and MEMWB_CLR=1 for 3 cycles, resume on the 4th, Stall_Count=3, state back to RUN.
- Timeout: Mem_Req=1, Mem_Ready=0 held 20 cycles with MEM_TIMEOUT=15 → Mem_Timeout_Err=1 after 15 cycles, pipeline stays frozen after Mem_Ready=1, cleared only by CLR=0.
- Async reset: assert CLR=0 mid-edge during MEMWAIT with Stall_Count=7 → Stall_Count=0, Err=0 and outputs at reset values before the next CLK edge.
